sdram_init_rfsh_seq: RTL
========================

Name: sdram_init_rfsh_seq

Overview:
Command sequencer that drives the SDRAM power-up sequence and periodic auto-refresh. The power-up sequence is: NOP wait, precharge-all, two auto-refreshes, then mode register load. It sits between the wishbone-side access arbiter and the SDRAM pins. It owns the command bus until init_done. After that it requests the bus from the arbiter for every refresh. The whitebox interface monitors its command stream.

Parameters:
INIT_WAIT, 10000, number of NOP cycles after reset release before the precharge.
SDRAM_TRP_D, 2, number of NOP cycles after precharge.
SDRAM_TRCAR_D, 7, number of NOP cycles after each auto-refresh.
SDRAM_TMRD_D, 2, number of NOP cycles after the mode register load.
SDRAM_RFSH, 256, refresh interval in sdram_clk cycles between refresh due points.
CAS_LAT, 3, CAS latency written to mode register bits [6:4]. Legal values are 2 and 3.
BURST_LEN, 3'b011, burst length field written to mode register bits [2:0].
ADDR_W, 13, SDRAM address width.

Ports:
sdram_clk  in  1  SDRAM clock. Sole clock of the block.
sdram_rst  in  1  Synchronous, active-high reset.
rfsh_gnt  in  1  Arbiter grant: command bus is free and all banks are precharged.
sdram_cke  out  1  Clock enable.
sdram_cs_n  out  1  Chip select.
sdram_ras_n  out  1  RAS.
sdram_cas_n  out  1  CAS.
sdram_we_n  out  1  WE.
sdram_addr  out  ADDR_W  Address bus. A10=1 on precharge-all; mode word on LMR.
cmd_own  out  1  High while this block drives the command pins. Arbiter output mux select.
init_done  out  1  Sticky high once the power-up sequence is complete.
rfsh_req  out  1  Refresh request to the arbiter.
rfsh_pending  out  3  Count of owed refreshes.

Behaviour:
- Reset values while sdram_rst=1 (all outputs registered):
  - cke=0, cs_n=0, ras_n=cas_n=we_n=1 (NOP), addr=0.
  - cmd_own=1, init_done=0, rfsh_req=0, rfsh_pending=0, FSM=INIT_WAIT, counters cleared.
- Reset mid-operation discards any sequence in progress and restarts from INIT_WAIT.
- The FSM runs in this order. Each wait state emits NOP for exactly the listed number of cycles.
  - INIT_WAIT: cke=1 from the first post-reset cycle; INIT_WAIT NOPs.
  - PRE: one cycle, ras=0 cas=1 we=0, A10=1.
  - TRP: SDRAM_TRP_D NOPs.
  - AREF1: one cycle, ras=0 cas=0 we=1.
  - TRC1: SDRAM_TRCAR_D NOPs.
  - AREF2, then TRC2: same as AREF1/TRC1.
  - LMR: one cycle, ras=cas=we=0, addr={0,CAS_LAT[2:0],1'b0 (sequential),BURST_LEN}.
  - TMRD: SDRAM_TMRD_D NOPs.
  - IDLE.
- Entering IDLE: init_done=1, cmd_own=0, refresh interval counter cleared.
- Interval counter:
  - Counts sdram_clk cycles in every post-init state.
  - On reaching SDRAM_RFSH-1 it wraps to 0 and rfsh_pending increments.
  - rfsh_pending saturates at 7; an overflow is dropped.
- rfsh_req = init_done and (rfsh_pending != 0), registered.
- Grant handling:
  - In IDLE, rfsh_gnt=1 with rfsh_req=1 causes cmd_own=1 on the next cycle, together with the AREF command. State moves to RFSH_AREF.
  - rfsh_gnt while rfsh_req=0 is ignored.
  - rfsh_gnt is sampled only in IDLE.
- Each RFSH_AREF is followed by RFSH_TRC, which emits SDRAM_TRCAR_D NOPs.
- After RFSH_TRC: if pending is still non-zero, issue another AREF; otherwise return to IDLE with cmd_own=0.
  - All owed refreshes are therefore drained in one ownership window.
- Pending decrements on every AREF cycle.
- If the interval wrap and an AREF fall in the same cycle, pending is unchanged.
- In IDLE, cmd_own=0, and the pin outputs hold NOP (the arbiter mux ignores them).
- cas_n never pulses low outside AREF/LMR. The block never issues READ/WRITE/ACTIVE.

Optional Feature:
Macro: SDRAM_RFSH_URGENT_EN.
- Defined:
  - Extra output rfsh_urgent (1 bit), registered, high when rfsh_pending >= 4.
  - While urgent, rfsh_req stays high and the arbiter must stop issuing new ACTIVE commands.
  - Pending saturation at 7 raises a one-shot $error in simulation.
- Undefined: port absent, no check; saturation drops silently.

Test Plan:
1. Power-up sequence.
   - Stimulus: pulse sdram_rst for 5 cycles, hold rfsh_gnt=0.
   - Required response:
     - 10000 NOPs with cke=1.
     - PRE with addr[10]=1, then 2 NOPs, then AREF, then 7 NOPs, then AREF, then 7 NOPs.
     - LMR with addr=13'h0033 (CAS_LAT=3, BURST_LEN=3'b011), then 2 NOPs.
     - init_done=1 and cmd_own=0.
2. Single refresh.
   - Stimulus: after init, hold rfsh_gnt=1.
   - Required response:
     - rfsh_req rises 256 cycles after IDLE entry.
     - AREF one cycle after grant.
     - cmd_own is high for exactly 8 cycles.
     - The next AREF follows 256 cycles later.
3. Postponed refreshes.
   - Stimulus: hold rfsh_gnt=0 for 3×256 cycles, then grant.
   - Required response:
     - rfsh_pending=3.
     - Three AREFs spaced 8 cycles apart, with no interleaving.
     - pending returns to 0 and cmd_own drops.
4. Saturation and urgent flag.
   - Stimulus: hold gnt=0 for 10 intervals, with SDRAM_RFSH_URGENT_EN defined.
   - Required response:
     - rfsh_urgent rises when pending reaches 4.
     - pending holds at 7.
     - A grant drains it with 7 AREFs.
5. Reset mid-refresh.
   - Stimulus: assert sdram_rst during RFSH_TRC.
   - Required response: the next cycle shows NOP, cke=0, init_done=0, rfsh_req=0, pending=0, and the full init sequence restarts.
6. Spurious grant and simultaneous events.
   - Stimulus: pulse rfsh_gnt with rfsh_req=0; separately, align the interval wrap with an AREF.
   - Required response: the spurious grant produces no command; the aligned case leaves the pending count unchanged.

Source files
------------

// File: rtl/sdram_init_rfsh_seq.sv
// SDRAM power-up command sequencer and periodic auto-refresh bus owner.
// Define SDRAM_RFSH_URGENT_EN to add rfsh_urgent and a saturation warning.
module sdram_init_rfsh_seq #(
    parameter int         INIT_WAIT     = 10000,
    parameter int         SDRAM_TRP_D   = 2,
    parameter int         SDRAM_TRCAR_D = 7,
    parameter int         SDRAM_TMRD_D  = 2,
    parameter int         SDRAM_RFSH    = 256,
    parameter int         CAS_LAT       = 3,
    parameter logic [2:0] BURST_LEN     = 3'b011,
    parameter int         ADDR_W        = 13
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              rfsh_gnt,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              cmd_own,
    output logic              init_done,
    output logic              rfsh_req,
`ifdef SDRAM_RFSH_URGENT_EN
    output logic              rfsh_urgent,
`endif
    output logic [2:0]        rfsh_pending
);

    localparam int TMR_W = $clog2(INIT_WAIT + SDRAM_TRP_D + SDRAM_TRCAR_D + SDRAM_TMRD_D + 1);
    localparam int IVL_W = $clog2(SDRAM_RFSH);

    localparam logic [TMR_W-1:0]  INIT_LD = TMR_W'(INIT_WAIT - 1);
    localparam logic [TMR_W-1:0]  TRP_LD  = TMR_W'(SDRAM_TRP_D - 1);
    localparam logic [TMR_W-1:0]  TRC_LD  = TMR_W'(SDRAM_TRCAR_D - 1);
    localparam logic [TMR_W-1:0]  TMRD_LD = TMR_W'(SDRAM_TMRD_D - 1);
    localparam logic [IVL_W-1:0]  IVL_LD  = IVL_W'(SDRAM_RFSH - 1);

    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_AREF = 3'b001;
    localparam logic [2:0] CMD_LMR  = 3'b000;

    localparam logic [ADDR_W-1:0] A10_WORD  = ADDR_W'(1) << 10;
    localparam logic [ADDR_W-1:0] MODE_WORD = ADDR_W'({3'(CAS_LAT), 1'b0, BURST_LEN});

    // state        | meaning
    // INIT_WAIT    | power-up NOP wait, cke already high
    // PRE / TRP    | precharge-all, then tRP NOPs
    // AREFn / TRCn | init auto-refresh n, then tRC NOPs
    // LMR / TMRD   | mode register load, then tMRD NOPs
    // IDLE         | bus released to arbiter, waiting for grant
    // RFSH_*       | owned refresh window: AREF, then tRC NOPs
    typedef enum logic [3:0] {
        S_INIT_WAIT, S_PRE, S_TRP, S_AREF1, S_TRC1, S_AREF2, S_TRC2,
        S_LMR, S_TMRD, S_IDLE, S_RFSH_AREF, S_RFSH_TRC
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [IVL_W-1:0]  ivl_q, ivl_d;
    logic [2:0]        pend_q, pend_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cke_q;
    logic              own_q, own_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              wrap, aref_now, tc;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        ivl_d    = ivl_q;
        pend_d   = pend_q;
        wrap     = 1'b0;
        aref_now = (state_q == S_RFSH_AREF);
        tc       = (tmr_q == '0);

        unique case (state_q)
            S_INIT_WAIT: begin
                // cke_q low means this is the first cycle out of reset
                if (!cke_q)  tmr_d = INIT_LD;
                else if (tc) state_d = S_PRE;
                else         tmr_d = tmr_q - 1'b1;
            end
            S_PRE:       begin state_d = S_TRP;  tmr_d = TRP_LD; end
            S_TRP:       if (tc) state_d = S_AREF1; else tmr_d = tmr_q - 1'b1;
            S_AREF1:     begin state_d = S_TRC1; tmr_d = TRC_LD; end
            S_TRC1:      if (tc) state_d = S_AREF2; else tmr_d = tmr_q - 1'b1;
            S_AREF2:     begin state_d = S_TRC2; tmr_d = TRC_LD; end
            S_TRC2:      if (tc) state_d = S_LMR; else tmr_d = tmr_q - 1'b1;
            S_LMR:       begin state_d = S_TMRD; tmr_d = TMRD_LD; end
            S_TMRD:      if (tc) state_d = S_IDLE; else tmr_d = tmr_q - 1'b1;
            S_IDLE:      if (rfsh_gnt && req_q) state_d = S_RFSH_AREF;
            S_RFSH_AREF: begin state_d = S_RFSH_TRC; tmr_d = TRC_LD; end
            S_RFSH_TRC: begin
                if (tc) state_d = (pend_q != 3'd0) ? S_RFSH_AREF : S_IDLE;
                else    tmr_d = tmr_q - 1'b1;
            end
            default:     state_d = S_INIT_WAIT;
        endcase

        if (done_q) begin
            if (ivl_q == '0) begin
                wrap  = 1'b1;
                ivl_d = IVL_LD;
            end else begin
                ivl_d = ivl_q - 1'b1;
            end
        end else if (state_d == S_IDLE) begin
            ivl_d = IVL_LD;
        end

        // a wrap coinciding with an AREF cancels out
        if (wrap && !aref_now)
            pend_d = (pend_q == 3'd7) ? 3'd7 : pend_q + 3'd1;
        else if (!wrap && aref_now && pend_q != 3'd0)
            pend_d = pend_q - 3'd1;

        cmd_d  = CMD_NOP;
        addr_d = '0;
        case (state_d)
            S_PRE:                         begin cmd_d = CMD_PRE; addr_d = A10_WORD; end
            S_AREF1, S_AREF2, S_RFSH_AREF: cmd_d = CMD_AREF;
            S_LMR:                         begin cmd_d = CMD_LMR; addr_d = MODE_WORD; end
            default:                       ;
        endcase

        own_d  = (state_d != S_IDLE);
        done_d = done_q | (state_d == S_IDLE);
        req_d  = done_d && (pend_d != 3'd0);
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q <= S_INIT_WAIT;
            tmr_q   <= '0;
            ivl_q   <= '0;
            pend_q  <= 3'd0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            cke_q   <= 1'b0;
            own_q   <= 1'b1;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ivl_q   <= ivl_d;
            pend_q  <= pend_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            cke_q   <= 1'b1;
            own_q   <= own_d;
            done_q  <= done_d;
            req_q   <= req_d;
        end
    end

`ifdef SDRAM_RFSH_URGENT_EN
    logic urgent_q, sat_seen_q, ovf;

    assign ovf = wrap && !aref_now && (pend_q == 3'd7);

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            urgent_q   <= 1'b0;
            sat_seen_q <= 1'b0;
        end else begin
            urgent_q   <= (pend_d >= 3'd4);
            sat_seen_q <= sat_seen_q | ovf;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst && ovf && !sat_seen_q)
            $error("sdram_init_rfsh_seq: refresh pending saturated, refresh dropped");
    end
`endif

    assign rfsh_urgent = urgent_q;
`endif

    assign sdram_cke    = cke_q;
    assign sdram_cs_n   = 1'b0;
    assign sdram_ras_n  = cmd_q[2];
    assign sdram_cas_n  = cmd_q[1];
    assign sdram_we_n   = cmd_q[0];
    assign sdram_addr   = addr_q;
    assign cmd_own      = own_q;
    assign init_done    = done_q;
    assign rfsh_req     = req_q;
    assign rfsh_pending = pend_q;

endmodule
